// File: rtl/assertion_pulse_checker_pkg.sv
// apc_pkg: shared state encoding and default limits for the assertion pulse checker
package apc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, STUCK = 2'd2} apc_state_e;
  localparam int DEF_MIN_HIGH = 2;
  localparam int DEF_MAX_HIGH = 8;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_STAT_W = 16;
endpackage

// File: rtl/assertion_pulse_checker_sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear that beats increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/assertion_pulse_checker.sv
// assertion_pulse_checker: classifies the high time of each sig_b pulse and keeps saturating statistics
module assertion_pulse_checker
  import apc_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH,
  parameter int MAX_HIGH = DEF_MAX_HIGH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sig_b,
  input  logic              enable,
  input  logic              clr_stats,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              pass_pulse,
  output logic              fail_short,
  output logic              fail_long,
  output logic [CNT_W-1:0]  high_len,
  output logic [STAT_W-1:0] assert_cnt,
  output logic [STAT_W-1:0] fail_cnt,
  output logic [1:0]        state
);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_HIGH);
  apc_state_e st;
  logic sig_q;
  logic [CNT_W-1:0] len;
  logic rise, inc_assert, inc_fail;
  assign rise = sig_b & ~sig_q;
  assign inc_assert = enable & (st == IDLE) & rise;
  // HIGH is only held while sig_b stays 1, so sig_b low there is a fall
  assign inc_fail = enable & (st == HIGH) & (sig_b ? len == MAX_L : len < MIN_L);
  assign state = st;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      sig_q <= 1'b0;
      len <= '0;
      high_len <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      pass_pulse <= 1'b0;
      fail_short <= 1'b0;
      fail_long <= 1'b0;
    end else begin
      sig_q <= sig_b;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      pass_pulse <= 1'b0;
      fail_short <= 1'b0;
      fail_long <= 1'b0;
      if (!enable) begin
        st <= IDLE;
        len <= '0;
      end else
        case (st)
          IDLE:
            if (rise) begin
              st <= HIGH;
              len <= CNT_W'(1);
              rise_pulse <= 1'b1;
            end
          HIGH:
            if (sig_b) begin
              len <= len + 1'b1;
              if (len == MAX_L) begin
                fail_long <= 1'b1;
                st <= STUCK;
              end
            end else begin
              fall_pulse <= 1'b1;
              high_len <= len;
              pass_pulse <= len >= MIN_L;
              fail_short <= len < MIN_L;
              st <= IDLE;
            end
          STUCK:
            if (sig_b) len <= (len == '1) ? len : len + 1'b1;
            else begin
              fall_pulse <= 1'b1;
              high_len <= len;
              st <= IDLE;
            end
          default: st <= IDLE;
        endcase
    end
  sat_counter #(.W(STAT_W)) u_assert_cnt (
    .clock(clock), .reset_n(reset_n), .inc(inc_assert), .clr(clr_stats), .q(assert_cnt)
  );
  sat_counter #(.W(STAT_W)) u_fail_cnt (
    .clock(clock), .reset_n(reset_n), .inc(inc_fail), .clr(clr_stats), .q(fail_cnt)
  );
endmodule

// File: tb/tb_assertion_pulse_checker.sv
// tb_assertion_pulse_checker: directed pulses with a strobe-event scoreboard
module tb_assertion_pulse_checker;
  localparam int MINH = 2;
  localparam int MAXH = 8;
  typedef struct {
    string       tag;
    logic [4:0]  st;
    logic [7:0]  hl;
    logic [15:0] ac;
    logic [15:0] fc;
  } ev_t;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic sig_b = 1'b0;
  logic enable = 1'b1;
  logic clr_stats = 1'b0;
  logic rise_pulse, fall_pulse, pass_pulse, fail_short, fail_long;
  logic [7:0] high_len;
  logic [15:0] assert_cnt, fail_cnt;
  logic [1:0] state;
  logic s2_rise, s2_fall, s2_pass, s2_short, s2_long;
  logic [7:0] s2_high_len;
  logic [1:0] s2_assert_cnt, s2_fail_cnt, s2_state;
  ev_t sb[$];
  logic [7:0] exp_hl;
  logic [15:0] exp_ac, exp_fc;
  int checks = 0;
  int errors = 0;
  assertion_pulse_checker dut (
    .clock(clock), .reset_n(reset_n), .sig_b(sig_b), .enable(enable), .clr_stats(clr_stats),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .pass_pulse(pass_pulse),
    .fail_short(fail_short), .fail_long(fail_long), .high_len(high_len),
    .assert_cnt(assert_cnt), .fail_cnt(fail_cnt), .state(state)
  );
  assertion_pulse_checker #(.STAT_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .sig_b(sig_b), .enable(enable), .clr_stats(clr_stats),
    .rise_pulse(s2_rise), .fall_pulse(s2_fall), .pass_pulse(s2_pass),
    .fail_short(s2_short), .fail_long(s2_long), .high_len(s2_high_len),
    .assert_cnt(s2_assert_cnt), .fail_cnt(s2_fail_cnt), .state(s2_state)
  );
  always #5 clock = ~clock;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic push(string tag, logic [4:0] st);
    sb.push_back('{tag, st, exp_hl, exp_ac, exp_fc});
  endtask
  task automatic monitor();
    logic [4:0] s;
    ev_t e;
    s = {rise_pulse, fall_pulse, pass_pulse, fail_short, fail_long};
    if (s != 5'b0) begin
      if (sb.size() == 0) chk("unexpected_strobe", 64'(s), 64'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_strobes"}, 64'(s), 64'(e.st));
        chk({e.tag, "_high_len"}, 64'(high_len), 64'(e.hl));
        chk({e.tag, "_assert_cnt"}, 64'(assert_cnt), 64'(e.ac));
        chk({e.tag, "_fail_cnt"}, 64'(fail_cnt), 64'(e.fc));
      end
    end
  endtask
  task automatic step(logic v);
    sig_b = v;
    @(posedge clock);
    #1;
    monitor();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", 64'({rise_pulse, fall_pulse, pass_pulse, fail_short, fail_long,
        high_len, assert_cnt, fail_cnt, state}), 64'd0);
    sb.delete();
    exp_hl = '0;
    exp_ac = '0;
    exp_fc = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  task automatic pulse(int n, string tag);
    if (exp_ac != 16'hffff) exp_ac++;
    push({tag, "_rise"}, 5'b10000);
    for (int i = 1; i <= n; i++) begin
      if (i == MAXH + 1) begin
        exp_fc++;
        push({tag, "_long"}, 5'b00001);
      end
      step(1'b1);
    end
    exp_hl = n > 255 ? 8'hff : 8'(n);
    if (n < MINH) exp_fc++;
    push({tag, "_fall"}, {1'b0, 1'b1, n >= MINH && n <= MAXH, n < MINH, 1'b0});
    step(1'b0);
  endtask
  task automatic drain(string tag);
    step(1'b0);
    step(1'b0);
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask
  initial begin
    #2;
    do_reset();
    pulse(4, "t1");
    chk("t1_fail_cnt", 64'(fail_cnt), 64'd0);
    drain("t1");
    do_reset();
    pulse(1, "t2");
    drain("t2");
    clr_stats = 1'b1;
    step(1'b0);
    clr_stats = 1'b0;
    chk("t2_clr_fail_cnt", 64'(fail_cnt), 64'd0);
    do_reset();
    pulse(12, "t3");
    drain("t3");
    pulse(2, "t3b2b_a");
    pulse(3, "t3b2b_b");
    drain("t3b2b");
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t4_disabled_state", 64'(state), 64'd0);
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("t4_no_rise_cnt", 64'(assert_cnt), 64'd0);
    step(1'b0);
    pulse(3, "t4");
    drain("t4");
    do_reset();
    exp_ac = 16'd1;
    push("t5_rise", 5'b10000);
    step(1'b1);
    step(1'b1);
    chk("t5_mid_state", 64'(state), 64'd1);
    do_reset();
    pulse(3, "t5_release");
    drain("t5");
    do_reset();
    pulse(4, "t6a");
    exp_ac = '0;
    push("t6_clr_rise", 5'b10000);
    clr_stats = 1'b1;
    step(1'b1);
    clr_stats = 1'b0;
    step(1'b1);
    step(1'b1);
    exp_hl = 8'd3;
    push("t6_fall", 5'b01100);
    step(1'b0);
    drain("t6");
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1, "t7");
    chk("t7_sat_assert_cnt", 64'(s2_assert_cnt), 64'd3);
    chk("t7_sat_fail_cnt", 64'(s2_fail_cnt), 64'd3);
    pulse(300, "t7_len_sat");
    drain("t7");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
